// File: rtl/arith_pkg.sv
// arith_pkg: shared ALUop bit positions, named op codes and the packed flag type
//   OP_FLAG_EN/OP_SUB/OP_USE_C/OP_SAT : ALUop bit indices
//   ADD/SUB/ADC/SBC/ADDS               : named op codes
//   flags_t                            : packed {C,V,Z,N}
package arith_pkg;
    localparam int OP_FLAG_EN = 0;
    localparam int OP_SUB     = 1;
    localparam int OP_USE_C   = 2;
    localparam int OP_SAT     = 3;
    localparam logic [3:0] ADD  = 4'b0001;
    localparam logic [3:0] SUB  = 4'b0011;
    localparam logic [3:0] ADC  = 4'b0101;
    localparam logic [3:0] SBC  = 4'b0111;
    localparam logic [3:0] ADDS = 4'b1001;
    typedef struct packed {
        logic C;
        logic V;
        logic Z;
        logic N;
    } flags_t;
endpackage

// File: rtl/arith_if.sv
// arith_if: operand/result handshake bundle of the arithmetic pipe
//   in_valid/in_ready, A, B, ALUop          : operation request
//   out_valid/out_ready, ArithOut, C,V,Z,N  : result and flags
//   carry_q                                 : stored carry
//   master = requester/consumer side, slave = pipe side
interface arith_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ArithOut;
    logic             C;
    logic             V;
    logic             Z;
    logic             N;
    logic             carry_q;
    modport master (
        output in_valid, A, B, ALUop, out_ready,
        input  in_ready, out_valid, ArithOut, C, V, Z, N, carry_q
    );
    modport slave (
        input  in_valid, A, B, ALUop, out_ready,
        output in_ready, out_valid, ArithOut, C, V, Z, N, carry_q
    );
endinterface

// File: rtl/arith_stage.sv
// arith_stage: one CHUNK-bit adder slice (slice K) with a registered hold/advance stage
//   clk, rst_n : clock, async active-low reset
//   en         : advance when 1, hold when 0
//   src_*      : op bundle from the previous stage
//   valid, op, a, fb, sum, carry : registered bundle for the next stage
module arith_stage #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             src_valid,
    input  logic [3:0]       src_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_fb,
    input  logic [WIDTH-1:0] src_sum,
    input  logic             src_carry,
    output logic             valid,
    output logic [3:0]       op,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] fb,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    logic [CHUNK:0]   part;
    logic [WIDTH-1:0] sum_next;

    assign part = {1'b0, src_a[K*CHUNK +: CHUNK]} + {1'b0, src_fb[K*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, src_carry};

    always_comb begin
        sum_next = src_sum;
        sum_next[K*CHUNK +: CHUNK] = part[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            op    <= '0;
            a     <= '0;
            fb    <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (en) begin
            valid <= src_valid;
            op    <= src_op;
            a     <= src_a;
            fb    <= src_fb;
            sum   <= sum_next;
            carry <= part[CHUNK];
        end
    end
endmodule

// File: rtl/arith_pipe.sv
// arith_pipe: pipelined add/subtract with carry chain split over WIDTH/CHUNK stages
//   clk, rst_n : clock, async active-low reset
//   bus        : arith_if slave (request handshake, result handshake, flags, carry_q)
//   Optional ARITH_SAT_EN: ALUop[3] clamps signed overflow to the extreme value
module arith_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic    clk,
    input logic    rst_n,
    arith_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    logic [STAGES:0]            vld;
    logic [STAGES:0][3:0]       op;
    logic [STAGES:0][WIDTH-1:0] a;
    logic [STAGES:0][WIDTH-1:0] fb;
    logic [STAGES:0][WIDTH-1:0] sum;
    logic [STAGES:0]            cy;
    logic                       stall;
    logic                       busy;
    logic [WIDTH-1:0]           raw;
    logic [WIDTH-1:0]           res;
    logic                       ovf;
    logic                       fe;
    flags_t                     fl;
    logic                       out_v;
    logic                       fe_q;
    logic                       cq;
    logic [WIDTH-1:0]           res_q;
    flags_t                     fl_q;
    logic                       unused_bits;

    assign stall = out_v & ~bus.out_ready;
    // ADC/SBC must see the carry of every older op, so it waits for an empty pipe
    assign busy = (|vld[STAGES:1]) | out_v;
    assign bus.in_ready = ~stall & ~(bus.in_valid & bus.ALUop[OP_USE_C] & busy);

    assign vld[0] = bus.in_valid & bus.in_ready;
    assign op[0]  = bus.ALUop;
    assign a[0]   = bus.A;
    assign fb[0]  = bus.ALUop[OP_SUB] ? ~bus.B : bus.B;
    assign sum[0] = '0;
    assign cy[0]  = bus.ALUop[OP_USE_C] ? cq : bus.ALUop[OP_SUB];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        arith_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .K(g)) u_stage (
            .clk(clk), .rst_n(rst_n), .en(~stall),
            .src_valid(vld[g]), .src_op(op[g]), .src_a(a[g]), .src_fb(fb[g]),
            .src_sum(sum[g]), .src_carry(cy[g]),
            .valid(vld[g+1]), .op(op[g+1]), .a(a[g+1]), .fb(fb[g+1]),
            .sum(sum[g+1]), .carry(cy[g+1])
        );
    end

    assign raw = sum[STAGES];
    assign fe  = op[STAGES][OP_FLAG_EN];
    assign ovf = ~(a[STAGES][WIDTH-1] ^ fb[STAGES][WIDTH-1]) & (a[STAGES][WIDTH-1] ^ raw[WIDTH-1]);
`ifdef ARITH_SAT_EN
    // on overflow the true sign is the opposite of the wrapped msb
    assign res = (op[STAGES][OP_SAT] & ovf) ? {~raw[WIDTH-1], {(WIDTH-1){raw[WIDTH-1]}}} : raw;
`else
    assign res = raw;
`endif
    assign fl = {cy[STAGES], ovf, ~|res, raw[WIDTH-1]} & {4{fe}};
    assign unused_bits = ^{a[STAGES][WIDTH-2:0], fb[STAGES][WIDTH-2:0], op[STAGES]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v <= 1'b0;
            res_q <= '0;
            fl_q  <= '0;
            fe_q  <= 1'b0;
            cq    <= 1'b0;
        end else begin
            if (!stall) begin
                out_v <= vld[STAGES];
                res_q <= res;
                fl_q  <= fl;
                fe_q  <= fe;
            end
            if (out_v & bus.out_ready & fe_q) cq <= fl_q.C;
        end
    end

    assign bus.out_valid = out_v;
    assign bus.ArithOut  = res_q;
    assign bus.C         = fl_q.C;
    assign bus.V         = fl_q.V;
    assign bus.Z         = fl_q.Z;
    assign bus.N         = fl_q.N;
    assign bus.carry_q   = cq;
endmodule
